// File: rtl/alu_sequencer.sv
// alu_sequencer: round-robin front end for a shared 8-bit accumulator ALU.
// Native ops run in a single execute cycle. MUL (low byte of an 8x8 product)
// runs as an 8-iteration shift-add loop through the same ALU: one add step,
// then one shift step per multiplier bit. Results come back tagged and registered.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic [7:0] alu_acc,
  output logic [7:0] alu_reg,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_rslt,
  input  logic       alu_zero,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_zero,
  output logic       rsp_err
);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SLL = 3'd2;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [2:0] {IDLE, EXEC, MUL_ADD, MUL_SHF, RESP} state_t;

  state_t     state_reg, state_next;
  logic       last_reg, last_next;       // id granted most recently
  logic [2:0] op_reg, op_next;           // native op select (bit 3 folded into err / MUL path)
  logic [7:0] a_reg, a_next;
  logic [7:0] b_reg, b_next;
  logic       id_reg, id_next;
  logic       err_reg, err_next;
  logic [7:0] prod_reg, prod_next;       // running product
  logic [7:0] mcand_reg, mcand_next;     // multiplicand, doubled each iteration
  logic [7:0] mplier_reg, mplier_next;   // multiplier, consumed LSB first
  logic [2:0] cnt_reg, cnt_next;         // iteration count, 0..7
  logic [7:0] data_reg, data_next;
  logic       zero_reg, zero_next;

  logic       grant0, grant1;
  logic [3:0] sel_op;
  logic [7:0] sel_a, sel_b;

  // Round-robin grant: on a tie the requester not served last wins; mux the winner's request.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_reg);
    grant1 = req1_valid && (!req0_valid || !last_reg);
    sel_op = grant1 ? req1_op : req0_op;
    sel_a  = grant1 ? req1_a  : req0_a;
    sel_b  = grant1 ? req1_b  : req0_b;
  end

  assign req0_ready = (state_reg == IDLE) && grant0;
  assign req1_ready = (state_reg == IDLE) && grant1;

  assign rsp_valid = (state_reg == RESP);
  assign rsp_id    = id_reg;
  assign rsp_data  = data_reg;
  assign rsp_zero  = zero_reg;
  assign rsp_err   = err_reg;

  // Next-state and ALU pin drive; every register holds unless its state updates it.
  always_comb begin
    state_next  = state_reg;
    last_next   = last_reg;
    op_next     = op_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    id_next     = id_reg;
    err_next    = err_reg;
    prod_next   = prod_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    cnt_next    = cnt_reg;
    data_next   = data_reg;
    zero_next   = zero_reg;
    alu_op      = OP_ADD;
    alu_acc     = 8'h00;
    alu_reg     = 8'h00;
    case (state_reg)
      IDLE: begin
        if (grant0 || grant1) begin
          id_next     = grant1;
          last_next   = grant1;
          op_next     = sel_op[2:0];
          a_next      = sel_a;
          b_next      = sel_b;
          err_next    = (sel_op > OP_MUL);
          prod_next   = 8'h00;
          mcand_next  = sel_a;
          mplier_next = sel_b;
          cnt_next    = 3'd0;
          state_next  = (sel_op == OP_MUL) ? MUL_ADD : EXEC;
        end
      end
      EXEC: begin
        // An illegal op still occupies the ALU slot but with a harmless Add and a zeroed result.
        alu_op     = err_reg ? OP_ADD : op_reg;
        alu_acc    = a_reg;
        alu_reg    = b_reg;
        data_next  = err_reg ? 8'h00 : alu_rslt;
        zero_next  = err_reg ? 1'b0 : alu_zero;
        state_next = RESP;
      end
      MUL_ADD: begin
        alu_op  = OP_ADD;
        alu_acc = mcand_reg;
        alu_reg = prod_reg;
        if (mplier_reg[0]) prod_next = alu_rslt;
        state_next = MUL_SHF;
      end
      MUL_SHF: begin
        alu_op      = OP_SLL;
        alu_acc     = mcand_reg;
        alu_reg     = 8'd1;
        mcand_next  = alu_rslt;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 3'd1;
        if (cnt_reg == 3'd7) begin
          data_next  = prod_reg;
          zero_next  = (prod_reg == 8'h00);
          state_next = RESP;
        end else begin
          state_next = MUL_ADD;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      last_reg   <= 1'b1;
      op_reg     <= 3'd0;
      a_reg      <= 8'h00;
      b_reg      <= 8'h00;
      id_reg     <= 1'b0;
      err_reg    <= 1'b0;
      prod_reg   <= 8'h00;
      mcand_reg  <= 8'h00;
      mplier_reg <= 8'h00;
      cnt_reg    <= 3'd0;
      data_reg   <= 8'h00;
      zero_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      last_reg   <= last_next;
      op_reg     <= op_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      id_reg     <= id_next;
      err_reg    <= err_next;
      prod_reg   <= prod_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      cnt_reg    <= cnt_next;
      data_reg   <= data_next;
      zero_reg   <= zero_next;
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU answers the DUT's pins, a
// transaction-level model predicts grants and responses every cycle, and
// directed requests pin the model with hand-computed results.
module tb_alu_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_op = '0, req1_op = '0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [7:0] alu_acc, alu_reg, alu_rslt;
  logic [2:0] alu_op;
  logic       alu_zero;
  logic       rsp_valid, rsp_id, rsp_zero, rsp_err;
  logic [7:0] rsp_data;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // model state
  bit         pend = 0;
  int         due = 0;
  bit         exp_id, exp_zero, exp_err;
  logic [7:0] exp_data;
  bit         last_m = 1;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_acc(alu_acc), .alu_reg(alu_reg), .alu_op(alu_op), .alu_rslt(alu_rslt), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator ALU: Add, Sub, Sll, Srl, Equ, Gtr (reg > acc), And, Xor.
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] acc, input logic [7:0] r);
    case (op)
      3'd0: return acc + r;
      3'd1: return acc - r;
      3'd2: return acc << r;
      3'd3: return acc >> r;
      3'd4: return (acc == r) ? 8'd1 : 8'd0;
      3'd5: return (r > acc) ? 8'd1 : 8'd0;
      3'd6: return acc & r;
      default: return acc ^ r;
    endcase
  endfunction

  always_comb begin
    alu_rslt = alu_f(alu_op, alu_acc, alu_reg);
    alu_zero = (alu_rslt == 8'h00);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the transaction model.
  always @(negedge clk) begin
    bit er0, er1;
    logic [3:0] op;
    logic [7:0] a, b;
    logic [15:0] p;
    if (!rst_n) begin
      pend = 0;
      last_m = 1;
    end else begin
      er0 = !pend && req0_valid && (!req1_valid || last_m);
      er1 = !pend && req1_valid && (!req0_valid || !last_m);
      check("ready", {30'd0, req1_ready, req0_ready}, {30'd0, er1, er0});
      if (!pend || cyc == due)
        check("alu_pins_idle", {13'd0, alu_op, alu_acc, alu_reg}, 32'd0);
      if (pend && cyc == due) begin
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_fields", {21'd0, rsp_id, rsp_data, rsp_zero, rsp_err},
              {21'd0, exp_id, exp_data, exp_zero, exp_err});
        if (rsp_valid)
          $display("rsp id=%0d data=0x%02h zero=%0d err=%0d", rsp_id, rsp_data, rsp_zero, rsp_err);
        pend = 0;
      end else begin
        check("rsp_idle", {31'd0, rsp_valid}, 32'd0);
      end
      if (er0 || er1) begin
        op = er1 ? req1_op : req0_op;
        a  = er1 ? req1_a : req0_a;
        b  = er1 ? req1_b : req0_b;
        exp_id = er1;
        last_m = er1;
        pend = 1;
        if (op == 4'd8) begin
          p = a * b;
          exp_data = p[7:0];
          exp_err = 0;
          due = cyc + 17;
        end else if (op > 4'd8) begin
          exp_data = 8'h00;
          exp_err = 1;
          due = cyc + 2;
        end else begin
          exp_data = alu_f(op[2:0], a, b);
          exp_err = 0;
          due = cyc + 2;
        end
        exp_zero = !exp_err && (exp_data == 8'h00);
      end
    end
  end

  task automatic drive(input bit id, input bit v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    if (id) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
  endtask

  function automatic bit rdy(input bit id);
    return id ? req1_ready : req0_ready;
  endfunction

  // One request: wait for handshake, then for the response; returns wait, latency and the EXEC-cycle alu_op.
  task automatic do_req(input bit id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int wcnt, output int lat, output logic [2:0] exec_op,
                        output logic [7:0] d, output logic z, output logic e, output logic rid);
    bit got;
    int k;
    wcnt = -1; lat = -1; exec_op = '1; d = 'x; z = 'x; e = 'x; rid = 'x;
    @(posedge clk); #1;
    drive(id, 1'b1, op, a, b);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rdy(id)) begin got = 1; wcnt = i; end
    end
    if (!got) begin
      check("handshake_timeout", 0, 1);
      drive(id, 1'b0, 4'd0, 8'd0, 8'd0);
      return;
    end
    @(posedge clk); #1;
    k = cyc;
    exec_op = alu_op;
    drive(id, 1'b0, 4'($urandom), 8'($urandom), 8'($urandom));
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; lat = cyc - k; d = rsp_data; z = rsp_zero; e = rsp_err; rid = rsp_id; end
    end
    if (!got) check("rsp_timeout", 0, 1);
    $display("req id=%0d op=%0d a=0x%02h b=0x%02h -> data=0x%02h zero=%0d err=%0d lat=%0d", id, op, a, b, d, z, e, lat);
  endtask

  task automatic pin(input string nm, input bit id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input int exp_lat, input logic [7:0] ed, input logic ez, input logic ee);
    int w, l;
    logic [2:0] xo;
    logic [7:0] d;
    logic z, e, rid;
    do_req(id, op, a, b, w, l, xo, d, z, e, rid);
    check({nm, "_lat"}, l, exp_lat);
    check({nm, "_res"}, {20'd0, rid, d, z, e}, {20'd0, id, ed, ez, ee});
    if (ee) check({nm, "_exec_op"}, {29'd0, xo}, 32'd0);
  endtask

  task automatic async_reset_check(input string nm);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check({nm, "_rsp"}, {20'd0, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err}, 32'd0);
    check({nm, "_pins"}, {11'd0, alu_op, alu_acc, alu_reg, req0_ready, req1_ready}, 32'd0);
    repeat (2) @(negedge clk);
    check({nm, "_no_rsp"}, {31'd0, rsp_valid}, 32'd0);
    #1 rst_n = 1'b1;
  endtask

  task automatic rand_driver(input bit id, input int n);
    bit got;
    int r;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      r = $urandom_range(0, 9);
      drive(id, 1'b1, (r == 9) ? 4'($urandom_range(9, 15)) : 4'(r), 8'($urandom), 8'($urandom));
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
        @(negedge clk);
        if (rdy(id)) got = 1;
      end
      if (!got) check("rand_handshake_timeout", 0, 1);
      @(posedge clk); #1;
      drive(id, 1'b0, 4'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    int w, l;
    logic [2:0] xo;
    logic [7:0] d;
    logic z, e, rid;
    int order[4];
    bit got;

    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    async_reset_check("reset");

    // First request after release is accepted in its first cycle.
    do_req(1'b0, 4'd1, 8'd5, 8'd5, w, l, xo, d, z, e, rid);
    check("post_reset_ready_wait", w, 0);
    check("sub_5_5", {21'd0, rid, d, z, e, 2'(l)}, {21'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd1});
    pin("gtr_3_9", 1'b1, 4'd5, 8'd3, 8'd9, 1, 8'h01, 1'b0, 1'b0);
    pin("mul_13_11", 1'b0, 4'd8, 8'd13, 8'd11, 16, 8'h8F, 1'b0, 1'b0);
    pin("mul_16_16", 1'b1, 4'd8, 8'd16, 8'd16, 16, 8'h00, 1'b1, 1'b0);
    pin("mul_255_255", 1'b0, 4'd8, 8'd255, 8'd255, 16, 8'h01, 1'b0, 1'b0);
    pin("illegal_12", 1'b1, 4'd12, 8'd7, 8'd3, 1, 8'h00, 1'b0, 1'b1);
    pin("xor", 1'b0, 4'd7, 8'hA5, 8'hA5, 1, 8'h00, 1'b1, 1'b0);

    // Reset in the middle of a MUL: dropped, then the next request proceeds.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 4'd8, 8'd200, 8'd3);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); if (req0_ready) got = 1; end
    if (!got) check("midmul_handshake", 0, 1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'd0, 8'd0, 8'd0);
    repeat (4) @(posedge clk);
    async_reset_check("reset_mid_mul");
    do_req(1'b0, 4'd8, 8'd200, 8'd3, w, l, xo, d, z, e, rid);
    check("mul_after_reset_wait", w, 0);
    check("mul_200_3", {22'd0, d, z, e}, {22'd0, 8'h58, 1'b0, 1'b0});

    // Fairness: both held valid from a fresh reset alternate 0,1,0,1.
    async_reset_check("reset_fair");
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 4'd0, 8'($urandom), 8'($urandom));
    drive(1'b1, 1'b1, 4'd0, 8'($urandom), 8'($urandom));
    for (int g = 0; g < 4; g++) begin
      got = 0;
      order[g] = -1;
      for (int i = 0; i < 30 && !got; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin got = 1; order[g] = req1_ready ? 1 : 0; end
      end
      @(posedge clk); #1;
      if (order[g] >= 0) drive(order[g][0], 1'b1, 4'd0, 8'($urandom), 8'($urandom));
      $display("grant %0d -> requester %0d", g, order[g]);
      check("fair_order", order[g], g % 2);
    end
    drive(1'b0, 1'b0, 4'd0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 4'd0, 8'd0, 8'd0);
    repeat (5) @(posedge clk);

    // Randomised contention from both requesters.
    fork
      rand_driver(1'b0, 40);
      rand_driver(1'b1, 40);
    join
    repeat (25) @(negedge clk);
    check("drained", {31'd0, pend}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
